// File: rtl/armleo_mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
//   NPORTS     : number of requesters sharing the memory cell
//   port_idx_t : index of one requester
//   port_vec_t : one bit per requester (valid/ready/response vectors)
package armleo_mem_arb_pkg;

  localparam int NPORTS = 2;

  typedef logic              port_idx_t;
  typedef logic [NPORTS-1:0] port_vec_t;

endpackage

// File: rtl/armleo_mem_1rw_arbiter_if.sv
// Request/response bundle between the requesters and the arbiter.
//   req_valid/req_ready : per-port handshake, bit i = port i
//   req_write           : per-port op, 1 = write, 0 = read
//   req_address         : port i address at [i*DEPTH_LOG2 +: DEPTH_LOG2]
//   req_writedata       : port i data at [i*WIDTH +: WIDTH]
//   resp_valid          : one-cycle pulse naming the port whose read completed
//   resp_readdata       : shared read data bus
// master = requester side, slave = arbiter side.
interface armleo_mem_1rw_arbiter_if
  import armleo_mem_arb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter int WIDTH      = 32
) ();

  port_vec_t                      req_valid;
  port_vec_t                      req_ready;
  port_vec_t                      req_write;
  logic [NPORTS*DEPTH_LOG2-1:0]   req_address;
  logic [NPORTS*WIDTH-1:0]        req_writedata;
  port_vec_t                      resp_valid;
  logic [WIDTH-1:0]               resp_readdata;

  modport master (
    output req_valid, req_write, req_address, req_writedata,
    input  req_ready, resp_valid, resp_readdata
  );

  modport slave (
    input  req_valid, req_write, req_address, req_writedata,
    output req_ready, resp_valid, resp_readdata
  );

endinterface

// File: rtl/armleo_mem_1rw.sv
// Single-port read-first memory cell.
//   clk       : clock
//   address   : word address
//   read      : capture storage[address] into readdata on the edge
//   readdata  : output register, holds until the next read
//   write     : store writedata at address on the edge
//   writedata : data to store
// Contents and the output register are not reset.
module armleo_mem_1rw #(
  parameter int DEPTH_LOG2 = 7,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] address,
  input  logic                  read,
  output logic [WIDTH-1:0]      readdata,
  input  logic                  write,
  input  logic [WIDTH-1:0]      writedata
);

  logic [WIDTH-1:0] storage [0:(2**DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (write) storage[address] <= writedata;
    if (read)  readdata <= storage[address];
  end

endmodule

// File: rtl/armleo_mem_1rw_arbiter.sv
// Two-requester round-robin arbiter in front of one armleo_mem_1rw cell.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of the request/response bundle
// At most one request is accepted per cycle; reads return one cycle later
// on resp_readdata, tagged by resp_valid with the issuing port.
module armleo_mem_1rw_arbiter
  import armleo_mem_arb_pkg::*;
#(
  parameter int DEPTH_LOG2 = 7,
  parameter int WIDTH      = 32
) (
  input  logic clk,
  input  logic rst_n,
  armleo_mem_1rw_arbiter_if.slave bus
);

  // Held low through the first edge after reset release so nothing is
  // accepted while the requesters are still coming out of reset.
  logic      en;
  // Port that wins when both are valid.
  port_idx_t prio;
  port_vec_t gnt;
  port_idx_t gnt_idx;
  port_vec_t rd_vld_p1;

  logic [DEPTH_LOG2-1:0] cell_addr;
  logic [WIDTH-1:0]      cell_wdata;
  logic [WIDTH-1:0]      cell_rdata;
  logic                  cell_read;
  logic                  cell_write;

  // Each grant bit is built from the valids and the pointer only, so one
  // port's ready never depends on the other port's ready.
  always_comb begin
    gnt = '0;
    if (en) begin
      gnt[0] = bus.req_valid[0] & (~bus.req_valid[1] | (prio == 1'b0));
      gnt[1] = bus.req_valid[1] & (~bus.req_valid[0] | (prio == 1'b1));
    end
  end

  assign gnt_idx    = gnt[1];
  assign cell_addr  = gnt_idx ? bus.req_address[DEPTH_LOG2 +: DEPTH_LOG2]
                              : bus.req_address[0 +: DEPTH_LOG2];
  assign cell_wdata = gnt_idx ? bus.req_writedata[WIDTH +: WIDTH]
                              : bus.req_writedata[0 +: WIDTH];
  assign cell_write = |(gnt & bus.req_write);
  assign cell_read  = |(gnt & ~bus.req_write);

  // Stage p0 -> p1: accepted read tagged with its port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en        <= 1'b0;
      prio      <= 1'b0;
      rd_vld_p1 <= '0;
    end else begin
      en        <= 1'b1;
      if (|gnt) prio <= ~gnt_idx;
      rd_vld_p1 <= gnt & ~bus.req_write;
    end
  end

  armleo_mem_1rw #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WIDTH)
  ) u_cell (
    .clk       (clk),
    .address   (cell_addr),
    .read      (cell_read),
    .readdata  (cell_rdata),
    .write     (cell_write),
    .writedata (cell_wdata)
  );

  assign bus.req_ready     = gnt;
  assign bus.resp_valid    = rd_vld_p1;
  assign bus.resp_readdata = cell_rdata;

endmodule
